qspi_byte_ctrl: RTL
===================

// Module: qspi_byte_ctrl
// PURPOSE
//  Register-mapped QSPI byte engine, downstream of the AXI-to-SPI interface.
//  Consumes the qspi_if_req/rsp byte channel: 3-bit register address, 8-bit data.
//  Drives the flash pins sck, csn and dq[3:0]; shifts one byte per DATA write,
//  in single (x1) or quad (x4) mode, SPI mode 0.
// PARAMETERS
//  DIV_W    8     width of clock-divider register
//  DEF_DIV  1     reset value of DIV; sck half-period = DIV+1 aclk cycles
// PORTS
//  aclk             in   1      clock
//  aresetn          in   1      synchronous active-low reset
//  qspi_if_req_vld  in   1      request valid
//  qspi_if_req_rdy  out  1      request ready
//  qspi_if_req_read in   1      1=read, 0=write
//  qspi_if_req_addr in   3      register address
//  qspi_if_req_dat  in   8      write data
//  qspi_if_rsp_vld  out  1      response valid
//  qspi_if_rsp_rdy  in   1      response ready
//  qspi_if_rsp_dat  out  8      read data (0 for writes)
//  qspi_if_sck      out  1      serial clock, idles low
//  qspi_if_csn      out  1      chip select, active low
//  qspi_if_dq_en    out  4      per-pin output enable
//  qspi_if_dq_o     out  4      pin output data
//  qspi_if_dq_i     in   4      pin input data
// BEHAVIOUR
//  Registers: 0 DATA (W: start xfer of byte; R: last rx byte); 1 CTRL [0]CS [1]QUAD
//   [2]QIN (quad receive, pins released) [3]LOOP; 2 DIV; 3 STATUS [0]busy (R only).
//   Addr 4-7: writes ignored, reads 0. Unused bits read 0.
//  Reset: FSM=IDLE, rsp_vld=0, rsp_dat=0, sck=0, csn=1, dq_en=0, dq_o=0,
//   CTRL=0, DIV=DEF_DIV, rx=0; req_rdy=1 after reset released.
//  req_rdy = (state==IDLE) & ~rsp_vld; one outstanding request; exactly one rsp each.
//  FSM IDLE->SHIFT on accepted DATA write; every other accepted req -> rsp_vld
//   next cycle (IDLE->RESP). SHIFT->RESP after last half-phase. RESP->IDLE on
//   rsp_vld & rsp_rdy. rsp_vld/rsp_dat stable while rsp_rdy=0.
//  SHIFT: nbits=8 (x1) or 2 (x4 nibbles), MSB/high nibble first. Each half-phase
//   DIV+1 cycles; first half low. dq_o updated on entry and each falling edge;
//   dq_i sampled on each rising edge. rsp_vld first high at T+1+2*nbits*(DIV+1),
//   T = acceptance cycle. STATUS.busy=1 only in SHIFT.
//  x1: dq_en=4'b1101, dq0=MOSI, dq1=MISO in, dq_o[3:2]=2'b11 (WP#/HOLD# high).
//  x4: dq_en=4'hF (QIN=0) or 4'h0 (QIN=1); sample dq_i[3:0].
//  dq_en=0 outside SHIFT; csn=~CTRL.CS at all times (software-framed commands).
//  Reset asserted mid-SHIFT: reset values next edge, transfer dropped, no rsp.
//  Next request acceptable earliest the cycle after the rsp handshake.
// CONFIGURATION
//  QSPI_LOOPBACK_EN defined: CTRL.LOOP=1 samples from internal dq_o instead of
//   dq_i (x1: dq0 -> rx bit; x4: dq_o[3:0]); pins behave unchanged.
//  Undefined: CTRL[3] not stored, reads 0, sampling always from dq_i.
// TESTING
//  Reset -> csn=1, sck=0, dq_en=0, req_rdy=1; read addr 3 -> rsp_dat=0x00.
//  DIV=0, CTRL=0x01, write DATA 0xA5, slave returns 0x3C on dq1 -> dq0 at rises
//   1,0,1,0,0,1,0,1; rsp at T+17; read DATA -> 0x3C; csn=0 throughout.
//  DIV=2, CTRL=0x03, write DATA 0x5A -> dq_en=F, dq_o 0x5 then 0xA, 2 sck
//   pulses of 6 cycles, rsp at T+13.
//  CTRL=0x07, drive dq_i 0xC then 0x3 -> dq_en=0, read DATA -> 0xC3.
//  Hold rsp_rdy=0 10 cycles -> rsp_vld/rsp_dat stable, req_rdy=0, no new accept.
//  Reset pulse mid-SHIFT -> csn=1, sck=0 next cycle, no rsp; with
//   QSPI_LOOPBACK_EN, CTRL=0x09, write 0x96 -> read DATA 0x96.

Source files
------------

// File: rtl/qspi_byte_ctrl.sv
// qspi_byte_ctrl: register-mapped QSPI byte engine, x1 or x4, SPI mode 0.
// Optional feature macro QSPI_LOOPBACK_EN: CTRL.LOOP feeds internal dq_o back into the receive path.
module qspi_byte_ctrl #(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DEF_DIV = 1
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       qspi_if_req_vld,
    output logic       qspi_if_req_rdy,
    input  logic       qspi_if_req_read,
    input  logic [2:0] qspi_if_req_addr,
    input  logic [7:0] qspi_if_req_dat,
    output logic       qspi_if_rsp_vld,
    input  logic       qspi_if_rsp_rdy,
    output logic [7:0] qspi_if_rsp_dat,
    output logic       qspi_if_sck,
    output logic       qspi_if_csn,
    output logic [3:0] qspi_if_dq_en,
    output logic [3:0] qspi_if_dq_o,
    input  logic [3:0] qspi_if_dq_i
);

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam logic [AW-1:0] A_DATA = AW'(0);
    localparam logic [AW-1:0] A_CTRL = AW'(1);
    localparam logic [AW-1:0] A_DIV  = AW'(2);
    localparam logic [AW-1:0] A_STAT = AW'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             ctrl_cs, ctrl_quad, ctrl_qin, ctrl_loop;
    logic [DIV_W-1:0] div_q, cnt_q;
    logic [2:0]       bit_q;
    logic [DW-1:0]    tx_q, rx_sh_q, rx_q;

    logic          accept_c, wr_c, start_c, ctrl_wr_c, div_wr_c;
    logic          half_end_c, rise_c, fall_c, last_bit_c, done_c;
    logic [DW-1:0] rd_dat_c, tx_nxt_c;
    logic [3:0]    en_c, rx_nib_c;
    logic          rx_bit_c;

    // Drive pattern for the current head of the shift byte.
    function automatic logic [3:0] pin_out(input logic [DW-1:0] b, input logic quad);
        return quad ? b[7:4] : {2'b11, 1'b0, b[7]};
    endfunction

    assign qspi_if_req_rdy = (state_q == IDLE) & ~qspi_if_rsp_vld;
    assign accept_c  = qspi_if_req_vld & qspi_if_req_rdy;
    assign wr_c      = accept_c & ~qspi_if_req_read;
    assign start_c   = wr_c & (qspi_if_req_addr == A_DATA);
    assign ctrl_wr_c = wr_c & (qspi_if_req_addr == A_CTRL);
    assign div_wr_c  = wr_c & (qspi_if_req_addr == A_DIV);

    assign half_end_c = (state_q == SHIFT) && (cnt_q == div_q);
    assign rise_c     = half_end_c & ~qspi_if_sck;
    assign fall_c     = half_end_c & qspi_if_sck;
    assign last_bit_c = (bit_q == (ctrl_quad ? 3'd1 : 3'd7));
    assign done_c     = fall_c & last_bit_c;

    assign tx_nxt_c = ctrl_quad ? {tx_q[3:0], 4'h0} : {tx_q[6:0], 1'b0};
    assign en_c     = ctrl_quad ? (ctrl_qin ? 4'h0 : 4'hF) : 4'b1101;

    // Receive source: pins normally, the driven pin values in loopback.
    assign rx_nib_c = ctrl_loop ? qspi_if_dq_o    : qspi_if_dq_i;
    assign rx_bit_c = ctrl_loop ? qspi_if_dq_o[0] : qspi_if_dq_i[1];

    always_comb begin
        rd_dat_c = '0;
        case (qspi_if_req_addr)
            A_DATA:  rd_dat_c = rx_q;
            A_CTRL:  rd_dat_c = {4'b0000, ctrl_loop, ctrl_qin, ctrl_quad, ctrl_cs};
            A_DIV:   rd_dat_c = DW'(div_q);
            A_STAT:  rd_dat_c = {7'b0000000, (state_q == SHIFT)};
            default: rd_dat_c = '0;
        endcase
    end

`ifdef QSPI_LOOPBACK_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ctrl_loop <= 1'b0;
        end else if (ctrl_wr_c) begin
            ctrl_loop <= qspi_if_req_dat[3];
        end
    end
`else
    assign ctrl_loop = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept_c) state_d = start_c ? SHIFT : RESP;
            SHIFT:   if (done_c) state_d = RESP;
            RESP:    if (qspi_if_rsp_vld && qspi_if_rsp_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registers, shifter and pin drivers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ctrl_cs         <= 1'b0;
            ctrl_quad       <= 1'b0;
            ctrl_qin        <= 1'b0;
            div_q           <= DIV_W'(DEF_DIV);
            cnt_q           <= '0;
            bit_q           <= '0;
            tx_q            <= '0;
            rx_sh_q         <= '0;
            rx_q            <= '0;
            qspi_if_rsp_vld <= 1'b0;
            qspi_if_rsp_dat <= '0;
            qspi_if_sck     <= 1'b0;
            qspi_if_csn     <= 1'b1;
            qspi_if_dq_en   <= '0;
            qspi_if_dq_o    <= '0;
        end else begin
            if (ctrl_wr_c) begin
                ctrl_cs     <= qspi_if_req_dat[0];
                ctrl_quad   <= qspi_if_req_dat[1];
                ctrl_qin    <= qspi_if_req_dat[2];
                qspi_if_csn <= ~qspi_if_req_dat[0];
            end
            if (div_wr_c) begin
                div_q <= DIV_W'(qspi_if_req_dat);
            end
            if (accept_c && !start_c) begin
                qspi_if_rsp_vld <= 1'b1;
                qspi_if_rsp_dat <= qspi_if_req_read ? rd_dat_c : '0;
            end
            if (start_c) begin
                tx_q          <= qspi_if_req_dat;
                cnt_q         <= '0;
                bit_q         <= '0;
                qspi_if_sck   <= 1'b0;
                qspi_if_dq_en <= en_c;
                qspi_if_dq_o  <= pin_out(qspi_if_req_dat, ctrl_quad);
            end
            if (state_q == SHIFT) begin
                if (half_end_c) begin
                    cnt_q       <= '0;
                    qspi_if_sck <= ~qspi_if_sck;
                end else begin
                    cnt_q <= cnt_q + DIV_W'(1);
                end
                if (rise_c) begin
                    rx_sh_q <= ctrl_quad ? {rx_sh_q[3:0], rx_nib_c} : {rx_sh_q[6:0], rx_bit_c};
                end
                if (fall_c) begin
                    if (last_bit_c) begin
                        qspi_if_rsp_vld <= 1'b1;
                        qspi_if_rsp_dat <= '0;
                        rx_q            <= rx_sh_q;
                        qspi_if_dq_en   <= '0;
                        qspi_if_dq_o    <= '0;
                    end else begin
                        bit_q        <= bit_q + 3'd1;
                        tx_q         <= tx_nxt_c;
                        qspi_if_dq_o <= pin_out(tx_nxt_c, ctrl_quad);
                    end
                end
            end
            if (qspi_if_rsp_vld && qspi_if_rsp_rdy) begin
                qspi_if_rsp_vld <= 1'b0;
            end
        end
    end

endmodule
